// File: rtl/axis_fifo_mux.sv
// Per-channel AXIS FIFOs merged onto one tagged sink with packet round-robin.
// Define FIFO_LEVEL_EN to expose per-channel occupancy on o_ch_level.
module axis_fifo_mux #(
    parameter int NUM_CH          = 4,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int CH_ID_WIDTH     = $clog2(NUM_CH),
    parameter int LVL_WIDTH       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                AXIS_clk,
    input  logic                                AXIS_rst,
    input  logic [NUM_CH-1:0]                   SRC_AXIS_tvalid,
    output logic [NUM_CH-1:0]                   SRC_AXIS_tready,
    input  logic [NUM_CH-1:0]                   SRC_AXIS_tlast,
    input  logic [NUM_CH-1:0]                   SRC_AXIS_tuser,
    input  logic [NUM_CH*AXIS_DATA_WIDTH-1:0]   SRC_AXIS_tdata,
    output logic                                SINK_AXIS_tvalid,
    input  logic                                SINK_AXIS_tready,
    output logic                                SINK_AXIS_tlast,
    output logic                                SINK_AXIS_tuser,
    output logic [AXIS_DATA_WIDTH-1:0]          SINK_AXIS_tdata,
    output logic [CH_ID_WIDTH-1:0]              SINK_AXIS_tid,
    input  logic [NUM_CH-1:0]                   i_ch_enable,
    input  logic [NUM_CH-1:0]                   i_ch_clear,
    output logic [NUM_CH-1:0]                   o_ch_empty,
    output logic [NUM_CH-1:0]                   o_ch_full
`ifdef FIFO_LEVEL_EN
    ,
    output logic [NUM_CH*LVL_WIDTH-1:0]         o_ch_level
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = AXIS_DATA_WIDTH + 2;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]             state;
    logic [CH_ID_WIDTH-1:0] grant;
    logic [CH_ID_WIDTH-1:0] last_grant;
    logic [CH_ID_WIDTH-1:0] pick;
    logic                   pick_found;

    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] elig;
    logic [EW-1:0]     head [NUM_CH];
    logic [EW-1:0]     sel;

    logic sink_valid;
    logic fire;

    assign SRC_AXIS_tready = ~full & ~i_ch_clear & {NUM_CH{~AXIS_rst}};
    assign push            = SRC_AXIS_tvalid & SRC_AXIS_tready;
    assign o_ch_empty      = empty;
    assign o_ch_full       = full;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [EW-1:0]        mem [FIFO_DEPTH];
        logic [LVL_WIDTH-1:0] wptr;
        logic [LVL_WIDTH-1:0] rptr;

        assign pop[c]  = fire && (grant == CH_ID_WIDTH'(c));
        assign head[c] = mem[rptr[AW-1:0]];

        always_ff @(posedge AXIS_clk) begin
            if (AXIS_rst || i_ch_clear[c]) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push[c]) wptr <= wptr + LVL_WIDTH'(1);
                if (pop[c])  rptr <= rptr + LVL_WIDTH'(1);
            end
        end

        always_ff @(posedge AXIS_clk) begin
            if (push[c])
                mem[wptr[AW-1:0]] <= {SRC_AXIS_tuser[c], SRC_AXIS_tlast[c],
                    SRC_AXIS_tdata[c*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]};
        end

`ifdef FIFO_LEVEL_EN
        logic [LVL_WIDTH-1:0] cnt;

        always_ff @(posedge AXIS_clk) begin
            if (AXIS_rst || i_ch_clear[c])
                cnt <= '0;
            else if (push[c] && !pop[c])
                cnt <= cnt + LVL_WIDTH'(1);
            else if (pop[c] && !push[c])
                cnt <= cnt - LVL_WIDTH'(1);
        end

        assign empty[c] = (cnt == '0);
        assign full[c]  = (cnt == LVL_WIDTH'(FIFO_DEPTH));
        assign o_ch_level[c*LVL_WIDTH +: LVL_WIDTH] = cnt;
`else
        // Extra MSB on each pointer tells full apart from empty.
        assign empty[c] = (wptr == rptr);
        assign full[c]  = (wptr[AW] != rptr[AW]) &&
                          (wptr[AW-1:0] == rptr[AW-1:0]);
`endif
    end

    // A channel being flushed this cycle would be granted with nothing to send.
    assign elig = i_ch_enable & ~empty & ~i_ch_clear;

    always_comb begin
        int                     idx;
        logic [CH_ID_WIDTH-1:0] cand;
        idx        = 0;
        cand       = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx  = (int'(last_grant) + i) % NUM_CH;
            cand = CH_ID_WIDTH'(idx);
            if (!pick_found && elig[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    assign sink_valid = (state == LOCKED) && !AXIS_rst &&
                        !empty[grant] && !i_ch_clear[grant];
    assign fire       = sink_valid && SINK_AXIS_tready;
    assign sel        = head[grant];

    assign SINK_AXIS_tvalid = sink_valid;
    assign SINK_AXIS_tdata  = sink_valid ? sel[AXIS_DATA_WIDTH-1:0] : '0;
    assign SINK_AXIS_tlast  = sink_valid && sel[EW-2];
    assign SINK_AXIS_tuser  = sink_valid && sel[EW-1];
    assign SINK_AXIS_tid    = sink_valid ? grant : '0;

    always_ff @(posedge AXIS_clk) begin
        if (AXIS_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_ID_WIDTH'(NUM_CH - 1);
        end else if (state == IDLE) begin
            if (pick_found) begin
                grant <= pick;
                state <= LOCKED;
            end
        end else begin
            if (i_ch_clear[grant] || (fire && sel[EW-2])) begin
                state      <= IDLE;
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_axis_fifo_mux.sv
// Directed bench for axis_fifo_mux: vector table plus multi-cycle sequences.
module tb_axis_fifo_mux;

    localparam int NC = 4;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int IW = 2;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   s_valid;
    logic [NC-1:0]   s_ready;
    logic [NC-1:0]   s_last;
    logic [NC-1:0]   s_user;
    logic [NC*W-1:0] s_data;
    logic            k_valid;
    logic            k_ready;
    logic            k_last;
    logic            k_user;
    logic [W-1:0]    k_data;
    logic [IW-1:0]   k_id;
    logic [NC-1:0]   en;
    logic [NC-1:0]   clr;
    logic [NC-1:0]   o_empty;
    logic [NC-1:0]   o_full;
`ifdef FIFO_LEVEL_EN
    logic [NC*LW-1:0] lvl;
`endif

    always #5 clk = ~clk;

    axis_fifo_mux #(
        .NUM_CH(NC), .AXIS_DATA_WIDTH(W), .FIFO_DEPTH(D)
    ) dut (
        .AXIS_clk(clk),
        .AXIS_rst(rst),
        .SRC_AXIS_tvalid(s_valid),
        .SRC_AXIS_tready(s_ready),
        .SRC_AXIS_tlast(s_last),
        .SRC_AXIS_tuser(s_user),
        .SRC_AXIS_tdata(s_data),
        .SINK_AXIS_tvalid(k_valid),
        .SINK_AXIS_tready(k_ready),
        .SINK_AXIS_tlast(k_last),
        .SINK_AXIS_tuser(k_user),
        .SINK_AXIS_tdata(k_data),
        .SINK_AXIS_tid(k_id),
        .i_ch_enable(en),
        .i_ch_clear(clr),
        .o_ch_empty(o_empty),
        .o_ch_full(o_full)
`ifdef FIFO_LEVEL_EN
        ,
        .o_ch_level(lvl)
`endif
    );

    typedef struct {
        logic            rst;
        logic [3:0]      sv;
        logic [3:0]      sl;
        logic [3:0][7:0] d;
        logic            rdy;
        logic            ev;
        logic            el;
        logic [1:0]      eid;
        logic [7:0]      ed;
        logic [3:0]      emp;
    } vec_t;

    vec_t tv[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   acc;

    task automatic add(input logic r, input logic [3:0] sv, input logic [3:0] sl,
                       input logic [3:0][7:0] d, input logic rdy, input logic ev,
                       input logic el, input logic [1:0] eid, input logic [7:0] ed,
                       input logic [3:0] emp);
        vec_t v;
        v.rst = r; v.sv = sv; v.sl = sl; v.d = d; v.rdy = rdy;
        v.ev = ev; v.el = el; v.eid = eid; v.ed = ed; v.emp = emp;
        tv.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setd(input int c, input logic [31:0] v);
        s_data[c*W +: W] = v;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [39:0] act;
        logic [39:0] exp;

        rst = 1'b1; s_valid = '0; s_last = '0; s_user = '0; s_data = '0;
        k_ready = 1'b0; en = 4'hF; clr = '0;
        tick(); tick(); tick();
        chk("rst_src_ready", s_ready, 4'h0);
        chk("rst_sink_valid", k_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", s_ready, 4'hF);
        chk("post_rst_flags", {o_empty, o_full}, {4'hF, 4'h0});
        chk("post_rst_sink", {k_valid, k_last, k_user, k_id, k_data}, '0);
`ifdef FIFO_LEVEL_EN
        chk("post_rst_level", lvl, '0);
`endif

        // single packet on ch1, then round robin over ch0/ch2/ch3
        add(0, 4'b0010, 4'b0000, {8'h00, 8'h00, 8'hA0, 8'h00}, 1, 0, 0, 0, 8'h00, 4'b1111);
        add(0, 4'b0010, 4'b0000, {8'h00, 8'h00, 8'hA1, 8'h00}, 1, 0, 0, 0, 8'h00, 4'b1101);
        add(0, 4'b0010, 4'b0010, {8'h00, 8'h00, 8'hA2, 8'h00}, 1, 1, 0, 1, 8'hA0, 4'b1101);
        add(0, 4'b0000, 4'b0000, '0, 1, 1, 0, 1, 8'hA1, 4'b1101);
        add(0, 4'b0000, 4'b0000, '0, 1, 1, 1, 1, 8'hA2, 4'b1101);
        add(0, 4'b0000, 4'b0000, '0, 1, 0, 0, 0, 8'h00, 4'b1111);
        add(1, 4'b0000, 4'b0000, '0, 0, 0, 0, 0, 8'h00, 4'b1111);
        add(0, 4'b1101, 4'b0000, {8'hD0, 8'hC0, 8'h00, 8'hB0}, 0, 0, 0, 0, 8'h00, 4'b1111);
        add(0, 4'b1101, 4'b1101, {8'hD1, 8'hC1, 8'h00, 8'hB1}, 0, 0, 0, 0, 8'h00, 4'b0010);
        add(0, 4'b0000, 4'b0000, '0, 0, 1, 0, 0, 8'hB0, 4'b0010);
        add(0, 4'b0000, 4'b0000, '0, 1, 1, 0, 0, 8'hB0, 4'b0010);
        add(0, 4'b0000, 4'b0000, '0, 1, 1, 1, 0, 8'hB1, 4'b0010);
        add(0, 4'b0000, 4'b0000, '0, 1, 0, 0, 0, 8'h00, 4'b0011);
        add(0, 4'b0000, 4'b0000, '0, 1, 1, 0, 2, 8'hC0, 4'b0011);
        add(0, 4'b0000, 4'b0000, '0, 1, 1, 1, 2, 8'hC1, 4'b0011);
        add(0, 4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'hB2}, 1, 0, 0, 0, 8'h00, 4'b0111);
        add(0, 4'b0000, 4'b0000, '0, 1, 1, 0, 3, 8'hD0, 4'b0110);
        add(0, 4'b0000, 4'b0000, '0, 1, 1, 1, 3, 8'hD1, 4'b0110);
        add(0, 4'b0000, 4'b0000, '0, 1, 0, 0, 0, 8'h00, 4'b1110);
        add(0, 4'b0000, 4'b0000, '0, 1, 1, 1, 0, 8'hB2, 4'b1110);
        add(0, 4'b0000, 4'b0000, '0, 1, 0, 0, 0, 8'h00, 4'b1111);

        for (int k = 0; k < tv.size(); k++) begin
            rst = tv[k].rst; s_valid = tv[k].sv; s_last = tv[k].sl;
            k_ready = tv[k].rdy;
            for (int c = 0; c < NC; c++) setd(c, {24'h0, tv[k].d[c]});
            #1;
            act = {k_valid, k_last, k_id, k_data, o_empty};
            exp = {tv[k].ev, tv[k].ev & tv[k].el, tv[k].ev ? tv[k].eid : 2'd0,
                   tv[k].ev ? {24'h0, tv[k].ed} : 32'h0, tv[k].emp};
            n_vec++;
            if (act !== exp) begin
                n_miss++;
                $display("FAIL vec%0d: got v=%b l=%b id=%0d d=%0h e=%b expected v=%b l=%b id=%0d d=%0h e=%b",
                    k, act[39], act[38], act[37:36], act[35:4], act[3:0],
                    exp[39], exp[38], exp[37:36], exp[35:4], exp[3:0]);
            end
            tick();
        end
        s_valid = '0; s_last = '0; s_data = '0; rst = 1'b0;

        // backpressure: fill ch0 past depth with sink stalled
        k_ready = 1'b0; s_valid = 4'b0001; acc = 0;
        for (int i = 0; i < D + 2; i++) begin
            setd(0, 32'hE0 + acc);
            s_user[0] = acc[0];
            s_last[0] = (acc == D - 1);
            #1;
            if (s_ready[0]) acc++;
            tick();
        end
        s_valid = '0; s_last = '0; s_user = '0;
        #1;
        chk("accepted", acc, D);
        chk("full_flag", o_full[0], 1'b1);
        chk("src_ready_low", s_ready[0], 1'b0);
        chk("stall_hold", {k_valid, k_data}, {1'b1, 32'hE0});
`ifdef FIFO_LEVEL_EN
        chk("level_full", lvl[LW-1:0], 4'd8);
`endif
        k_ready = 1'b1;
        for (int j = 0; j < D; j++) begin
            #1;
            chk($sformatf("drain%0d", j), {k_valid, k_last, k_user, k_data},
                {1'b1, 1'(j == D - 1), 1'(j % 2), 32'hE0 + 32'(j)});
            tick();
        end
        #1;
        chk("drain_flags", {o_empty[0], o_full[0]}, 2'b10);
`ifdef FIFO_LEVEL_EN
        chk("level_zero", lvl[LW-1:0], 4'd0);
`endif

        // clear ch2 mid-packet while ch3 waits
        k_ready = 1'b0; s_valid = 4'b1100; s_last = 4'b1000;
        setd(2, 32'hF0); setd(3, 32'h30);
        tick();
        s_valid = 4'b0100; s_last = '0; setd(2, 32'hF1);
        tick();
        setd(2, 32'hF2);
        tick();
        setd(2, 32'hF3); s_last = 4'b0100;
        tick();
        s_valid = '0; s_last = '0; k_ready = 1'b1;
        #1;
        chk("clr_first", {k_valid, k_id, k_data}, {1'b1, 2'd2, 32'hF0});
        tick();
        clr = 4'b0100;
        tick();
        clr = '0;
        #1;
        chk("clr_drop", {k_valid, o_empty[2]}, 2'b01);
        tick();
        #1;
        chk("clr_next", {k_valid, k_id, k_last, k_data}, {1'b1, 2'd3, 1'b1, 32'h30});
        tick();

        // enable gating
        en = 4'b1101; s_valid = 4'b0011; s_last = 4'b0010;
        setd(0, 32'h40); setd(1, 32'h11);
        tick();
        s_valid = 4'b0001; s_last = '0; setd(0, 32'h41);
        tick();
        setd(0, 32'h42); s_last = 4'b0001; en = 4'b1100;
        #1;
        chk("en_b0", {k_valid, k_id, k_last, k_data}, {1'b1, 2'd0, 1'b0, 32'h40});
        tick();
        s_valid = '0; s_last = '0;
        #1;
        chk("en_b1", {k_valid, k_id, k_last, k_data}, {1'b1, 2'd0, 1'b0, 32'h41});
        tick();
        s_valid = 4'b0001; s_last = 4'b0001; setd(0, 32'h43);
        #1;
        chk("en_b2", {k_valid, k_id, k_last, k_data}, {1'b1, 2'd0, 1'b1, 32'h42});
        tick();
        s_valid = '0; s_last = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("en_skip%0d", i), k_valid, 1'b0);
            tick();
        end
        #1;
        chk("en_pending", o_empty, 4'b1100);
        en = 4'b1110;
        tick();
        #1;
        chk("en_ch1", {k_valid, k_id, k_last, k_data}, {1'b1, 2'd1, 1'b1, 32'h11});
        tick();
        en = 4'hF;
        tick();
        #1;
        chk("en_ch0", {k_valid, k_id, k_last, k_data}, {1'b1, 2'd0, 1'b1, 32'h43});
        tick();

        // reset in the middle of a locked packet
        s_valid = 4'b1000; s_last = '0; setd(3, 32'h50);
        tick();
        setd(3, 32'h51);
        tick();
        setd(3, 32'h52); s_last = 4'b1000;
        #1;
        chk("rst_lock", {k_valid, k_id, k_data}, {1'b1, 2'd3, 32'h50});
        tick();
        s_valid = '0; s_last = '0; rst = 1'b1;
        tick();
        rst = 1'b0; s_valid = 4'b1001; s_last = 4'b1001;
        setd(0, 32'h60); setd(3, 32'h70);
        #1;
        chk("rst_after", {k_valid, o_empty, s_ready}, {1'b0, 4'hF, 4'hF});
        tick();
        s_valid = '0; s_last = '0;
        #1;
        chk("rst_idle", k_valid, 1'b0);
        tick();
        #1;
        chk("rst_grant0", {k_valid, k_id, k_last, k_data}, {1'b1, 2'd0, 1'b1, 32'h60});
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
